// File: rtl/chiplet_types_pkg.sv
// ---------------------------------------------------------------------------
// chiplet_types_pkg
// Shared types for the chiplet switch and its link transmitters.
//   PKG_NUM_VCS : virtual channel count shared by switch and link ports
//   vc_t        : virtual channel index
//   flit_t      : flit as emitted by the crossbar (vc selects the buffer)
//   link_beat_t : one link beat, a flit plus its tail flag
// ---------------------------------------------------------------------------
package chiplet_types_pkg;

    localparam int PKG_NUM_VCS = 2;
    localparam int FLIT_DATA_W = 16;

    typedef logic [$clog2(PKG_NUM_VCS)-1:0] vc_t;

    typedef struct packed {
        vc_t                    vc;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

    // Tail-flag convention: last=1 marks the final flit of a packet; the
    // flag travels with the flit through buffering and onto the link.
    typedef struct packed {
        flit_t flit;
        logic  last;
    } link_beat_t;

    localparam int LINK_BEAT_W = $bits(link_beat_t);

endpackage

// File: rtl/vc_fifo.sv
// ---------------------------------------------------------------------------
// vc_fifo
// Synchronous FIFO holding the flits of one virtual channel.
// A push while full is accepted only when a pop happens in the same cycle,
// so occupancy stays unchanged; otherwise the push is ignored here and the
// parent flags it.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request and data
//   pop           : read request (head is removed at the clock edge)
//   full, empty   : occupancy status
//   rdata         : current head entry (valid when !empty)
// ---------------------------------------------------------------------------
module vc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = r_mem[r_rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count define which entries are
    // meaningful, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/link_tx_port.sv
// ---------------------------------------------------------------------------
// link_tx_port
// Per-output-port link transmitter downstream of the switch crossbar.
// Buffers flits per VC, picks a VC round-robin among those with data and
// downstream credit, and drives a registered valid/ready link interface.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid        : flit present from the switch
//   in_flit,in_last : flit (vc selects buffer) and its tail flag
//   credit_granted  : per-VC pulse, one per local FIFO entry popped
//   packet_sent     : pulse when a tail flit completes its link handshake
//   link_valid      : output register holds a flit
//   link_flit       : flit on the link
//   link_last       : tail flag for link_flit
//   link_ready      : link accepts the flit this cycle
//   link_credit     : per-VC downstream credit return pulses
//   err             : sticky error (full-FIFO push or credit overflow)
// ---------------------------------------------------------------------------
module link_tx_port
    import chiplet_types_pkg::*;
#(
    parameter int NUM_VCS        = PKG_NUM_VCS,
    parameter int FIFO_DEPTH     = 4,
    parameter int DS_BUFFER_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  flit_t              in_flit,
    input  logic               in_last,
    output logic [NUM_VCS-1:0] credit_granted,
    output logic               packet_sent,
    output logic               link_valid,
    output flit_t              link_flit,
    output logic               link_last,
    input  logic               link_ready,
    input  logic [NUM_VCS-1:0] link_credit,
    output logic               err
);

    localparam int              CW         = $clog2(DS_BUFFER_SIZE + 1);
    localparam logic [CW-1:0]   CREDIT_MAX = CW'(DS_BUFFER_SIZE);

    link_beat_t w_beat_in;
    logic [LINK_BEAT_W-1:0] w_rdata [NUM_VCS];
    logic [NUM_VCS-1:0] w_push;
    logic [NUM_VCS-1:0] w_pop;
    logic [NUM_VCS-1:0] w_full;
    logic [NUM_VCS-1:0] w_empty;
    logic [NUM_VCS-1:0] w_eligible;
    logic [NUM_VCS-1:0] w_drop;
    logic [NUM_VCS-1:0] w_ovf;

    logic       w_grant_any;
    vc_t        w_grant_vc;
    logic       w_load;
    link_beat_t w_load_beat;

    vc_t   r_rr_ptr;
    logic  r_link_valid;
    flit_t r_link_flit;
    logic  r_link_last;
    logic  r_err;

    assign w_beat_in = '{flit: in_flit, last: in_last};

    // Load when the output register is empty or is being emptied this cycle.
    // Gating with rst keeps the reset cycle free of pops and pulses.
    assign w_load = !rst && w_grant_any && (!r_link_valid || link_ready);

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        logic [CW-1:0] r_credit;

        assign w_push[v]     = in_valid && (in_flit.vc == vc_t'(v));
        assign w_pop[v]      = w_load && (w_grant_vc == vc_t'(v));
        assign w_eligible[v] = !w_empty[v] && (r_credit != '0);
        // A full FIFO still takes a push when it is popped in the same cycle.
        assign w_drop[v]     = w_push[v] && w_full[v] && !w_pop[v];
        // Increment and decrement together cancel, so only a lone increment
        // at the maximum overflows.
        assign w_ovf[v]      = link_credit[v] && !w_pop[v] && (r_credit == CREDIT_MAX);

        vc_fifo #(
            .WIDTH (LINK_BEAT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push[v]),
            .wdata (w_beat_in),
            .pop   (w_pop[v]),
            .full  (w_full[v]),
            .empty (w_empty[v]),
            .rdata (w_rdata[v])
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_credit <= CREDIT_MAX;
            end else if (link_credit[v] && !w_pop[v]) begin
                if (r_credit != CREDIT_MAX) r_credit <= r_credit + 1'b1;
            end else if (w_pop[v] && !link_credit[v]) begin
                r_credit <= r_credit - 1'b1;
            end
        end
    end

    // Round-robin search starting at r_rr_ptr.
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned and infers a latch.
    always_comb begin
        vc_t idx;
        w_grant_any = 1'b0;
        w_grant_vc  = '0;
        idx         = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            idx = vc_t'((int'(r_rr_ptr) + i) % NUM_VCS);
            if (!w_grant_any && w_eligible[idx]) begin
                w_grant_any = 1'b1;
                w_grant_vc  = idx;
            end
        end
    end

    assign w_load_beat = link_beat_t'(w_rdata[w_grant_vc]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_link_valid <= 1'b0;
            r_link_flit  <= '0;
            r_link_last  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_load) begin
                r_rr_ptr     <= (w_grant_vc == vc_t'(NUM_VCS - 1)) ? '0 : w_grant_vc + 1'b1;
                r_link_valid <= 1'b1;
                r_link_flit  <= w_load_beat.flit;
                r_link_last  <= w_load_beat.last;
            end else if (link_ready) begin
                r_link_valid <= 1'b0;
            end
            if (|w_drop || |w_ovf) r_err <= 1'b1;
        end
    end

    assign credit_granted = w_pop;
    assign packet_sent    = !rst && r_link_valid && link_ready && r_link_last;
    assign link_valid     = r_link_valid;
    assign link_flit      = r_link_flit;
    assign link_last      = r_link_last;
    assign err            = r_err;

endmodule

// File: tb/tb_link_tx_port.sv
// ---------------------------------------------------------------------------
// tb_link_tx_port
// Scoreboard bench for link_tx_port: stimulus queues the expected link beats,
// a negedge monitor pops and compares on every link handshake.
// ---------------------------------------------------------------------------
module tb_link_tx_port;
    import chiplet_types_pkg::*;

    localparam int NV = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    flit_t         in_flit = '0;
    logic          in_last = 1'b0;
    logic [NV-1:0] credit_granted;
    logic          packet_sent;
    logic          link_valid;
    flit_t         link_flit;
    logic          link_last;
    logic          link_ready = 1'b0;
    logic [NV-1:0] link_credit = '0;
    logic          err;

    link_tx_port #(
        .NUM_VCS        (NV),
        .FIFO_DEPTH     (4),
        .DS_BUFFER_SIZE (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_flit        (in_flit),
        .in_last        (in_last),
        .credit_granted (credit_granted),
        .packet_sent    (packet_sent),
        .link_valid     (link_valid),
        .link_flit      (link_flit),
        .link_last      (link_last),
        .link_ready     (link_ready),
        .link_credit    (link_credit),
        .err            (err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         hs_cnt   = 0;
    int         cg_cnt [NV];
    link_beat_t exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted link beat must match the head of the scoreboard.
    always @(negedge clk) begin
        link_beat_t e;
        if (!rst) begin
            for (int v = 0; v < NV; v++) cg_cnt[v] += int'(credit_granted[v]);
            if (link_valid && link_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", {link_flit, link_last});
                end else begin
                    e = exp_q.pop_front();
                    check("link_beat", {link_flit, link_last}, e);
                    check("packet_sent", packet_sent, e.last);
                end
            end else if (packet_sent) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_packet_sent: got 1 expected 0");
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input int vc, input logic [15:0] d, input logic last);
        link_beat_t b;
        b.flit.vc   = vc_t'(vc);
        b.flit.data = d;
        b.last      = last;
        exp_q.push_back(b);
    endtask

    task automatic send(input int vc, input logic [15:0] d, input logic last, input bit fwd);
        @(posedge clk);
        #1;
        in_valid     = 1'b1;
        in_flit.vc   = vc_t'(vc);
        in_flit.data = d;
        in_last      = last;
        if (fwd) expect_beat(vc, d, last);
    endtask

    task automatic stop_in();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        in_valid    = 1'b0;
        link_credit = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int cg0;
        logic [17:0] hold_exp;
        for (int v = 0; v < NV; v++) cg_cnt[v] = 0;

        // Reset and idle
        link_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle_valid", link_valid, 1'b0);
        end
        check("reset_credit0", dut.g_vc[0].r_credit, 8);
        check("reset_credit1", dut.g_vc[1].r_credit, 8);
        check("reset_err", err, 1'b0);
        check("reset_cg", credit_granted, 2'b00);

        // Single tail flit: credit pulse one cycle after push, beat the next
        send(0, 16'h00A5, 1'b1, 1'b1);
        stop_in();
        @(negedge clk);
        check("single_cg", credit_granted, 2'b01);
        check("single_valid_early", link_valid, 1'b0);
        @(negedge clk);
        check("single_valid", link_valid, 1'b1);
        check("single_ps", packet_sent, 1'b1);
        tick(3);
        check("single_drain", exp_q.size(), 0);

        // Credit exhaustion on vc1: 8 of 10 flits go out
        do_reset();
        hs0 = hs_cnt;
        cg0 = cg_cnt[1];
        for (int i = 0; i < 10; i++) send(1, 16'h0100 + 16'(i), (i == 9), (i < 8));
        stop_in();
        tick(6);
        check("exh_fwd", hs_cnt - hs0, 8);
        check("exh_cg", cg_cnt[1] - cg0, 8);
        check("exh_credit", dut.g_vc[1].r_credit, 0);
        check("exh_valid", link_valid, 1'b0);
        expect_beat(1, 16'h0108, 1'b0);
        link_credit = 2'b10;
        tick(1);
        link_credit = 2'b00;
        tick(4);
        check("exh_fwd9", hs_cnt - hs0, 9);
        check("exh_cg9", cg_cnt[1] - cg0, 9);
        check("exh_drain", exp_q.size(), 0);

        // Backpressure then round-robin alternation at full rate
        do_reset();
        link_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(0, 16'h00A0 + 16'(k), (k == 2), 1'b1);
            send(1, 16'h00B0 + 16'(k), (k == 2), 1'b1);
        end
        stop_in();
        tick(2);
        hold_exp = {1'b1, 1'b0, 16'h00A0};
        repeat (5) begin
            @(negedge clk);
            check("bp_hold", {link_valid, link_flit}, hold_exp);
            check("bp_hold_last", link_last, 1'b0);
        end
        @(posedge clk);
        #1;
        link_ready = 1'b1;
        hs0 = hs_cnt;
        repeat (6) @(negedge clk);
        #1;
        check("bp_rate", hs_cnt - hs0, 6);
        tick(3);
        check("bp_drain", exp_q.size(), 0);

        // Push into a full FIFO: dropped, err set, only 5 flits emerge
        do_reset();
        link_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(0, 16'h00C0 + 16'(k), (k == 4), 1'b1);
        stop_in();
        @(negedge clk);
        check("full_err_before", err, 1'b0);
        send(0, 16'h00CF, 1'b1, 1'b0);
        stop_in();
        @(negedge clk);
        check("full_err", err, 1'b1);
        @(posedge clk);
        #1;
        link_ready = 1'b1;
        hs0 = hs_cnt;
        tick(8);
        check("full_fwd", hs_cnt - hs0, 5);
        check("full_drain", exp_q.size(), 0);
        check("full_err_sticky", err, 1'b1);

        // Credit return at maximum: err set, counter saturates
        do_reset();
        check("ovf_err_before", err, 1'b0);
        link_credit = 2'b01;
        tick(1);
        link_credit = 2'b00;
        @(negedge clk);
        check("ovf_err", err, 1'b1);
        check("ovf_credit", dut.g_vc[0].r_credit, 8);
        tick(2);
        check("ovf_err_sticky", err, 1'b1);

        // Mid-transfer reset with one held and three buffered flits
        do_reset();
        link_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(0, 16'h00D0 + 16'(k), 1'b1, 1'b0);
        stop_in();
        tick(2);
        check("mid_held", link_valid, 1'b1);
        rst        = 1'b1;
        link_ready = 1'b1;
        @(negedge clk);
        check("mid_ps_rst", packet_sent, 1'b0);
        check("mid_cg_rst", credit_granted, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_valid", link_valid, 1'b0);
        check("mid_flit", link_flit, 17'h0);
        check("mid_last", link_last, 1'b0);
        check("mid_err", err, 1'b0);
        check("mid_credit0", dut.g_vc[0].r_credit, 8);
        hs0 = hs_cnt;
        tick(5);
        check("mid_discard", hs_cnt - hs0, 0);
        check("mid_valid_after", link_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/link_tx_port.md
# link_tx_port

Per-output-port link transmitter that sits directly downstream of the switch crossbar. It accepts flits the switch emits on one output port, buffers them per virtual channel, and forwards them onto the inter-chiplet link over a valid/ready handshake. Forwarding is gated by per-VC credit counters that track free space in the next hop's input buffers. It returns `credit_granted` and `packet_sent` pulses to the switch so the crossbar can release allocations and reuse buffer space.

## Interface
Parameters:
- `NUM_VCS`, 2, number of virtual channels. Must equal the switch's `NUM_VCS`.
- `FIFO_DEPTH`, 4, entries per local VC FIFO. Power of two, ≥2.
- `DS_BUFFER_SIZE`, 8, downstream buffer depth per VC. This is the initial and maximum credit count.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: flit present from the switch's `data_ready_out` bit for this port.
- `in_flit` in `flit_t`: flit from the switch; `in_flit.vc` selects the VC FIFO.
- `in_last` in 1: the flit is the tail of its packet.
- `credit_granted` out `NUM_VCS`: one-cycle pulse per FIFO entry popped, per VC.
- `packet_sent` out 1: one-cycle pulse when a tail flit completes its link handshake.
- `link_valid` out 1: output register holds a flit.
- `link_flit` out `flit_t`: flit on the link.
- `link_last` out 1: tail flag accompanying `link_flit`.
- `link_ready` in 1: the link accepts the flit this cycle.
- `link_credit` in `NUM_VCS`: downstream credit return, one pulse per freed slot.
- `err` out 1: sticky error flag.

## Operation
- **Write.** When `in_valid`, `{in_flit, in_last}` is pushed into FIFO[`in_flit.vc`].
  - A push to a full FIFO is dropped and sets `err`.
  - The switch is expected to respect credits, so a full-FIFO push indicates an upstream bug.
- **Eligibility.** VC v is eligible when FIFO[v] is non-empty and `credit[v] > 0`.
- **Output register.** The register loads when it is empty, or when it is full and `link_ready` is high in the same cycle (zero-bubble).
  - Load source: round-robin choice among eligible VCs.
  - The round-robin pointer advances to one past the granted VC.
- **On load:**
  - Pop the granted FIFO.
  - Pulse `credit_granted[v]` in the same cycle.
  - Decrement `credit[v]`.
- **Hold.** While `link_valid && !link_ready`, `link_flit` and `link_last` hold stable.
- **Handshake complete.** When `link_valid && link_ready` and `link_last`, pulse `packet_sent` in that cycle.
- **Credit counters.** Width is `$clog2(DS_BUFFER_SIZE+1)`.
  - Increment on `link_credit[v]`.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - An increment at `DS_BUFFER_SIZE` saturates the counter and sets `err`.
- **`err`.** Cleared only by `rst`.

## Timing
Reset values (all synchronous to `rst`):
- FIFOs empty; `link_valid`=0, `link_flit`='0, `link_last`=0.
- `credit[v]`=`DS_BUFFER_SIZE`.
- RR pointer = 0.
- `credit_granted`=0, `packet_sent`=0, `err`=0.

Latency and throughput:
- Flit pushed in cycle N → earliest `link_valid` in cycle N+2. The FIFO write is visible in N+1, and the output register loads at the end of N+1.
- With `link_ready`=1 and credits available: one flit per cycle sustained, with no bubbles between VCs.

Boundary behaviour:
- **Credit = 0 on all non-empty VCs:** `link_valid` drops after the current flit is accepted. Loading resumes the cycle after a `link_credit` arrives. That cycle is an eligibility cycle, so the flit appears on the link one cycle later.
- **Push to a FIFO in the same cycle it is popped:** allowed, even when the FIFO is full; occupancy is unchanged.
- **Push to an empty FIFO:** not eligible until the next cycle (no bypass).
- **`rst` asserted mid-transfer:** discards all buffered flits and the held output flit. Credits restore to `DS_BUFFER_SIZE`, and no pulses are emitted in the reset cycle.

## Structure
- Shared items in `chiplet_types_pkg`:
  - `flit_t`, including its `vc` field.
  - A new `vc_t` typedef of width `$clog2(NUM_VCS)`.
  - The tail-flag convention for link beats.
- One sub-module: `vc_fifo`.
  - A parameterized synchronous FIFO with `push`, `pop`, `full`, `empty`, `rdata`.
  - Instantiated `NUM_VCS` times.
- The round-robin arbiter, credit counters and output register stay in `link_tx_port`.

## Test plan
- **Reset check:** after `rst`, hold `link_ready`=1 and send no input → `link_valid`=0 forever; credits observable at 8/8.
- **Single tail flit:** single flit vc0 `in_last`=1 at cycle 10, `link_ready`=1 → `link_valid` at cycle 12, `credit_granted`=2'b01 at cycle 11, `packet_sent` at cycle 12.
- **Credit exhaustion:** 10 flits on vc1 with no `link_credit`, `FIFO_DEPTH`=4, `DS_BUFFER_SIZE`=8 → exactly 8 flits forwarded and 2 remain buffered. Pulse `link_credit[1]` once → the 9th flit is forwarded and `credit_granted[1]` pulses once.
- **Backpressure:** hold `link_ready`=0 for 5 cycles with both VCs loaded → `link_flit` stable for all 5 cycles. On release, the VCs alternate vc0, vc1, vc0, … one per cycle.
- **Error paths:** push a 5th flit into full FIFO[0] with `link_ready`=0 → `err`=1, FIFO still holds 4. Separately, a `link_credit[0]` pulse at credit 8 → `err`=1, counter stays 8.
- **Mid-transfer reset:** assert `rst` while 3 flits are buffered and one is held → next cycle all outputs are at their reset values and no `packet_sent` is emitted.
